// File: rtl/stream_join_n.sv
// N-channel stream join: each channel buffers into its own FIFO, and one beat per
// enabled channel is popped together into a registered, zero-filled output word.
module stream_join_n #(
    parameter int NUM_CH       = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_ADDR_SZ = 1,
    parameter int OUT_WIDTH    = NUM_CH * DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_CH-1:0]                    i_valid,
    output logic [NUM_CH-1:0]                    i_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         i_data,
    input  logic [NUM_CH-1:0]                    i_ch_mask,
    input  logic                                 i_clear,
    output logic                                 o_valid,
    input  logic                                 o_ready,
    output logic [OUT_WIDTH-1:0]                 o_data,
    output logic [NUM_CH*(FIFO_ADDR_SZ+1)-1:0]   o_level,
    output logic                                 o_skew_err
);

    localparam int                    DEPTH    = 1 << FIFO_ADDR_SZ;
    localparam int                    LW       = FIFO_ADDR_SZ + 1;
    localparam logic [LW-1:0]         FULL_CNT = LW'(DEPTH);
    localparam logic [LW-1:0]         CNT_ONE  = LW'(1);
    localparam logic [FIFO_ADDR_SZ-1:0] PTR_ONE = FIFO_ADDR_SZ'(1);

    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     empty;
    logic [NUM_CH-1:0]     wr_en;
    logic [NUM_CH-1:0]     rd_en;
    logic [DATA_WIDTH-1:0] head [NUM_CH];
    logic [OUT_WIDTH-1:0]  joined;
    logic                  all_ok;
    logic                  fire;
    logic                  skew_now;

    assign i_ready  = ~full;
    assign all_ok   = (|i_ch_mask) && ((i_ch_mask & empty) == '0);
    assign fire     = all_ok && (!o_valid || o_ready) && !i_clear;
    // A full FIFO can never be empty, so any hit on both terms involves two distinct channels.
    assign skew_now = (|(i_ch_mask & full)) && (|(i_ch_mask & empty));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0]   mem [DEPTH];
        logic [FIFO_ADDR_SZ-1:0] wr_ptr;
        logic [FIFO_ADDR_SZ-1:0] rd_ptr;
        logic [LW-1:0]           count;

        assign full[c]  = (count == FULL_CNT);
        assign empty[c] = (count == '0);
        assign wr_en[c] = i_valid[c] && !full[c] && !i_clear;
        assign rd_en[c] = fire && i_ch_mask[c];
        assign head[c]  = mem[rd_ptr];
        assign o_level[c*LW +: LW] = count;

        always_ff @(posedge clk) begin
            if (wr_en[c]) mem[wr_ptr] <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (i_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en[c]) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_en[c]) rd_ptr <= rd_ptr + PTR_ONE;
                case ({wr_en[c], rd_en[c]})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Masked slots are zero in the joined word.
    always_comb begin
        joined = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_ch_mask[c]) joined[c*DATA_WIDTH +: DATA_WIDTH] = head[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_skew_err <= 1'b0;
        end else if (i_clear) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_skew_err <= 1'b0;
        end else begin
            if (fire) begin
                o_valid <= 1'b1;
                o_data  <= joined;
            end else if (o_ready) begin
                o_valid <= 1'b0;
                o_data  <= '0;
            end
            if (skew_now) o_skew_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_join_n.sv
// Directed bench for stream_join_n (3 channels, 8-bit beats, depth 2) with an output scoreboard.
module tb_stream_join_n;

    localparam int NUM_CH = 3;
    localparam int DW     = 8;
    localparam int AS     = 1;
    localparam int OW     = NUM_CH * DW;
    localparam int LVW    = NUM_CH * (AS + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] i_valid;
    logic [NUM_CH-1:0] i_ready;
    logic [OW-1:0]     i_data;
    logic [NUM_CH-1:0] i_ch_mask;
    logic              i_clear;
    logic              o_valid;
    logic              o_ready;
    logic [OW-1:0]     o_data;
    logic [LVW-1:0]    o_level;
    logic              o_skew_err;

    int          total  = 0;
    int          passed = 0;
    int          cyc    = 0;
    logic        mon_en = 1'b0;
    logic [OW-1:0] exp_q [$];

    stream_join_n #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FIFO_ADDR_SZ(AS)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .i_ch_mask(i_ch_mask), .i_clear(i_clear),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_level(o_level), .o_skew_err(o_skew_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    endtask

    // Output monitor: every accepted beat is checked against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) chk("beat_with_empty_scoreboard", 32'(o_valid), 32'd0);
                else chk("out_beat", 32'(o_data), 32'(exp_q.pop_front()));
            end else if (!o_valid) begin
                chk("idle_data_zero", 32'(o_data), 32'd0);
            end
        end
    end

    task automatic wait_accept();
        logic [NUM_CH-1:0] acc;
        int n = 0;
        while (i_valid != '0 && n < 20) begin
            @(negedge clk);
            acc = i_valid & i_ready;
            @(posedge clk);
            #1;
            i_valid = i_valid & ~acc;
            n++;
        end
        if (i_valid != '0) begin
            chk("accept_timeout", 32'(i_valid), 32'd0);
            i_valid = '0;
        end
    endtask

    task automatic send(input logic [NUM_CH-1:0] v, input logic [7:0] d2, input logic [7:0] d1,
                        input logic [7:0] d0);
        i_valid = v;
        i_data  = {d2, d1, d0};
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    initial begin
        int t0;
        // Reset with random inputs
        reset_n = 1'b0;
        i_clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid   = NUM_CH'($urandom);
            i_data    = OW'($urandom);
            i_ch_mask = NUM_CH'($urandom);
            i_clear   = 1'($urandom);
            o_ready   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_level", 32'(o_level), 32'd0);
        chk("rst_skew", 32'(o_skew_err), 32'd0);
        i_valid = '0; i_clear = 1'b0; i_ch_mask = 3'b111; o_ready = 1'b1; i_data = '0;
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_i_ready", 32'(i_ready), 32'h7);
        mon_en = 1'b1;

        // Streaming: 1 beat/cycle, one-cycle latency
        t0 = cyc;
        for (int v = 1; v <= 8; v++) begin
            exp_q.push_back({8'(v), 8'(v), 8'(v)});
            send(3'b111, 8'(v), 8'(v), 8'(v));
            if (v == 1) chk("first_beat_not_yet_valid", 32'(o_valid), 32'd0);
        end
        chk("throughput_cycles", 32'(cyc - t0), 32'd8);
        drain();

        // Stall with all inputs valid
        o_ready = 1'b0;
        exp_q.push_back(24'h323130);
        exp_q.push_back(24'h424140);
        exp_q.push_back(24'h525150);
        exp_q.push_back(24'h626160);
        send(3'b111, 8'h32, 8'h31, 8'h30);
        send(3'b111, 8'h42, 8'h41, 8'h40);
        send(3'b111, 8'h52, 8'h51, 8'h50);
        i_valid = 3'b111;
        i_data  = 24'h626160;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("stall_o_valid", 32'(o_valid), 32'd1);
            chk("stall_o_data", 32'(o_data), 32'h323130);
            chk("stall_level", 32'(o_level), 32'h2A);
            chk("stall_i_ready", 32'(i_ready), 32'd0);
        end
        o_ready = 1'b1;
        wait_accept();
        drain();

        // Mask 101 with ch1 idle, then 111 blocks
        i_ch_mask = 3'b101;
        for (int v = 0; v < 3; v++) begin
            exp_q.push_back({8'(8'h80 + v), 8'h00, 8'(8'h70 + v)});
            send(3'b101, 8'(8'h80 + v), 8'hEE, 8'(8'h70 + v));
        end
        drain();
        chk("mask_ch1_level", 32'(o_level[3:2]), 32'd0);
        i_ch_mask = 3'b111;
        send(3'b101, 8'h90, 8'hEE, 8'h88);
        repeat (3) @(posedge clk);
        #1;
        chk("mask_blocked_valid", 32'(o_valid), 32'd0);
        chk("mask_blocked_level", 32'(o_level), 32'h11);
        exp_q.push_back(24'h90B088);
        send(3'b010, 8'h00, 8'hB0, 8'h00);
        drain();

        // Skew: ch0 runs ahead of ch1
        i_ch_mask = 3'b011;
        send(3'b001, 8'h00, 8'h00, 8'h10);
        send(3'b001, 8'h00, 8'h00, 8'h11);
        chk("skew_ready0_low", 32'(i_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("skew_err_set", 32'(o_skew_err), 32'd1);
        chk("skew_no_output", 32'(o_valid), 32'd0);
        exp_q.push_back(24'h00A010);
        send(3'b011, 8'h00, 8'hA0, 8'h12);
        drain();
        o_ready = 1'b0;
        send(3'b010, 8'h00, 8'hA1, 8'h00);
        @(posedge clk);
        #1;
        chk("skew_second_valid", 32'(o_valid), 32'd1);
        chk("skew_second_data", 32'(o_data), 32'h00A111);
        send(3'b001, 8'h00, 8'h00, 8'h13);
        chk("pre_clear_level", 32'(o_level), 32'h02);
        chk("pre_clear_skew", 32'(o_skew_err), 32'd1);

        // Clear with inputs presented in the same cycle
        i_clear = 1'b1;
        i_valid = 3'b111;
        i_data  = 24'hDDCCBB;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        i_valid = '0;
        chk("clear_level", 32'(o_level), 32'd0);
        chk("clear_o_valid", 32'(o_valid), 32'd0);
        chk("clear_o_data", 32'(o_data), 32'd0);
        chk("clear_skew", 32'(o_skew_err), 32'd0);
        chk("clear_i_ready", 32'(i_ready), 32'h7);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_inputs_dropped", 32'(o_level), 32'd0);
        chk("clear_no_output", 32'(o_valid), 32'd0);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
